// File: rtl/half_adder_rr_scheduler.sv
// Round-robin front end that shares one streaming half-adder engine between
// NUM_REQ requesters. One transaction in flight: grant, send both operands,
// collect sum and carry, hold the response until taken. A watchdog turns a
// stalled engine into an error response instead of a hang.
module half_adder_rr_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int WDOG_CYCLES = 64,
  localparam int IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  // requesters
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [NUM_REQ-1:0] req_a,
  input  logic [NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0] req_ready,
  // engine operand streams
  output logic               ha_a_tvalid,
  output logic               ha_a_tdata,
  input  logic               ha_a_tready,
  output logic               ha_b_tvalid,
  output logic               ha_b_tdata,
  input  logic               ha_b_tready,
  // engine result streams
  input  logic               ha_sum_tvalid,
  input  logic               ha_sum_tdata,
  output logic               ha_sum_tready,
  input  logic               ha_carry_tvalid,
  input  logic               ha_carry_tdata,
  output logic               ha_carry_tready,
  // response stream
  output logic               rsp_valid,
  output logic               rsp_sum,
  output logic               rsp_carry,
  output logic               rsp_err,
  output logic [IDW-1:0]     rsp_id,
  input  logic               rsp_ready,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, SEND, COLLECT, RESP} state_t;

  localparam logic [15:0] WDOG_LIM = 16'(WDOG_CYCLES - 1);

  state_t          state, state_nxt;
  logic [IDW-1:0]  rr_ptr, id_q, sel, cand;
  logic            found, accept, timeout;
  logic            op_a, op_b;
  logic            a_done, b_done, sum_done, carry_done;
  logic            a_hs, b_hs, sum_hs, carry_hs;
  logic            sum_q, carry_q, err_q;
  logic [15:0]     wdog;
  logic            wdog_hit;

  assign wdog_hit = (wdog == WDOG_LIM);

  // First valid requester at or above rr_ptr, wrapping; power-of-two
  // NUM_REQ lets the index simply overflow.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = rr_ptr + IDW'(i);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state plus all handshake-facing outputs. Handshake terms are
  // derived after the valid/ready they depend on within the same pass.
  always_comb begin
    state_nxt       = state;
    req_ready       = '0;
    accept          = 1'b0;
    timeout         = 1'b0;
    ha_a_tvalid     = 1'b0;
    ha_b_tvalid     = 1'b0;
    ha_sum_tready   = 1'b0;
    ha_carry_tready = 1'b0;
    a_hs            = 1'b0;
    b_hs            = 1'b0;
    sum_hs          = 1'b0;
    carry_hs        = 1'b0;
    rsp_valid       = 1'b0;
    busy            = 1'b0;
    case (state)
      IDLE: begin
        if (found && !reset) begin
          req_ready = NUM_REQ'(1) << sel;
          accept    = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        busy        = 1'b1;
        ha_a_tvalid = !a_done;
        ha_b_tvalid = !b_done;
        a_hs        = ha_a_tvalid & ha_a_tready;
        b_hs        = ha_b_tvalid & ha_b_tready;
        if (wdog_hit) begin
          timeout   = 1'b1;
          state_nxt = RESP;
        end else if ((a_done | a_hs) && (b_done | b_hs)) begin
          state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        busy            = 1'b1;
        ha_sum_tready   = !sum_done;
        ha_carry_tready = !carry_done;
        sum_hs          = ha_sum_tready & ha_sum_tvalid;
        carry_hs        = ha_carry_tready & ha_carry_tvalid;
        // A result landing on the watchdog's last cycle still counts.
        if ((sum_done | sum_hs) && (carry_done | carry_hs)) begin
          state_nxt = RESP;
        end else if (wdog_hit) begin
          timeout   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand data is only meaningful while its valid is up.
  assign ha_a_tdata = ha_a_tvalid & op_a;
  assign ha_b_tdata = ha_b_tvalid & op_b;

  // Response fields are zero outside RESP so nothing leaks during reset/idle.
  assign rsp_sum   = rsp_valid & sum_q;
  assign rsp_carry = rsp_valid & carry_q;
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_id    = rsp_valid ? id_q : '0;

  // Transaction datapath: capture on grant, track handshakes, run watchdog.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr     <= '0;
      id_q       <= '0;
      op_a       <= 1'b0;
      op_b       <= 1'b0;
      a_done     <= 1'b0;
      b_done     <= 1'b0;
      sum_done   <= 1'b0;
      carry_done <= 1'b0;
      sum_q      <= 1'b0;
      carry_q    <= 1'b0;
      err_q      <= 1'b0;
      wdog       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_a       <= req_a[sel];
            op_b       <= req_b[sel];
            id_q       <= sel;
            rr_ptr     <= sel + IDW'(1);
            wdog       <= '0;
            a_done     <= 1'b0;
            b_done     <= 1'b0;
            sum_done   <= 1'b0;
            carry_done <= 1'b0;
            sum_q      <= 1'b0;
            carry_q    <= 1'b0;
            err_q      <= 1'b0;
          end
        end
        SEND: begin
          wdog <= wdog + 16'd1;
          if (a_hs) a_done <= 1'b1;
          if (b_hs) b_done <= 1'b1;
        end
        COLLECT: begin
          wdog <= wdog + 16'd1;
          if (sum_hs) begin
            sum_done <= 1'b1;
            sum_q    <= ha_sum_tdata;
          end
          if (carry_hs) begin
            carry_done <= 1'b1;
            carry_q    <= ha_carry_tdata;
          end
        end
        default: ;
      endcase
      // Expired watchdog discards any partial result.
      if (timeout) begin
        sum_q   <= 1'b0;
        carry_q <= 1'b0;
        err_q   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_half_adder_rr_scheduler.sv
// Directed bench: a table of transactions with hand-computed grants and
// results, driven against a configurable-latency engine model, plus a
// hand-written mid-transaction reset sequence.
module tb_half_adder_rr_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_valid, req_a, req_b, req_ready;
  logic       ha_a_tvalid, ha_a_tdata, ha_a_tready;
  logic       ha_b_tvalid, ha_b_tdata, ha_b_tready;
  logic       ha_sum_tvalid, ha_sum_tdata, ha_sum_tready;
  logic       ha_carry_tvalid, ha_carry_tdata, ha_carry_tready;
  logic       rsp_valid, rsp_sum, rsp_carry, rsp_err, rsp_ready, busy;
  logic [1:0] rsp_id;

  int errors = 0;
  int checks = 0;

  // engine knobs: wait cycles before ready/valid, and a never-answer switch
  int aw, bw, sw, cw;
  bit never_sum;
  int a_cnt, b_cnt, s_cnt, c_cnt;
  logic ea, eb;

  half_adder_rr_scheduler #(.NUM_REQ(4), .WDOG_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .ha_a_tvalid(ha_a_tvalid), .ha_a_tdata(ha_a_tdata), .ha_a_tready(ha_a_tready),
    .ha_b_tvalid(ha_b_tvalid), .ha_b_tdata(ha_b_tdata), .ha_b_tready(ha_b_tready),
    .ha_sum_tvalid(ha_sum_tvalid), .ha_sum_tdata(ha_sum_tdata), .ha_sum_tready(ha_sum_tready),
    .ha_carry_tvalid(ha_carry_tvalid), .ha_carry_tdata(ha_carry_tdata),
    .ha_carry_tready(ha_carry_tready),
    .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
    .rsp_id(rsp_id), .rsp_ready(rsp_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Engine model, updated on the falling edge so the DUT sees stable inputs.
  always @(negedge clk) begin
    if (reset) begin
      ha_a_tready = 0; ha_b_tready = 0;
      ha_sum_tvalid = 0; ha_sum_tdata = 0; ha_carry_tvalid = 0; ha_carry_tdata = 0;
      a_cnt = 0; b_cnt = 0; s_cnt = 0; c_cnt = 0;
    end else begin
      if (ha_a_tvalid) begin
        ha_a_tready = (a_cnt >= aw);
        if (ha_a_tready) ea = ha_a_tdata;
        a_cnt++;
      end else begin ha_a_tready = 0; a_cnt = 0; end
      if (ha_b_tvalid) begin
        ha_b_tready = (b_cnt >= bw);
        if (ha_b_tready) eb = ha_b_tdata;
        b_cnt++;
      end else begin ha_b_tready = 0; b_cnt = 0; end
      if (ha_sum_tready) begin
        ha_sum_tvalid = !never_sum && (s_cnt >= sw);
        ha_sum_tdata  = ea ^ eb;
        s_cnt++;
      end else begin ha_sum_tvalid = 0; s_cnt = 0; end
      if (ha_carry_tready) begin
        ha_carry_tvalid = (c_cnt >= cw);
        ha_carry_tdata  = ea & eb;
        c_cnt++;
      end else begin ha_carry_tvalid = 0; c_cnt = 0; end
    end
  end

  typedef struct {
    logic [3:0] valid, a, b;
    int         id;
    logic       sum, carry, err;
    int         aw, bw, sw, cw, rw;
    bit         never, zlat;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] v, a, b, input int id,
                              input logic s, c, e, input int aw_, bw_, sw_, cw_, rw_,
                              input bit nv, zl);
    vec_t t;
    t.valid = v; t.a = a; t.b = b; t.id = id; t.sum = s; t.carry = c; t.err = e;
    t.aw = aw_; t.bw = bw_; t.sw = sw_; t.cw = cw_; t.rw = rw_; t.never = nv; t.zlat = zl;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic txn(input vec_t t);
    int cyc;
    logic [3:0] gnt;
    aw = t.aw; bw = t.bw; sw = t.sw; cw = t.cw; never_sum = t.never;
    @(negedge clk);
    req_valid = t.valid; req_a = t.a; req_b = t.b;
    #1;
    gnt = 4'b0001 << t.id;
    chk("grant", req_ready, gnt);
    chk("busy_idle", busy, 0);
    @(posedge clk); #1;
    cyc = 1;
    while (!rsp_valid && cyc < 40) begin
      chk("no_grant_while_busy", req_ready, 0);
      chk("busy_active", busy, 1);
      @(posedge clk); #1;
      cyc++;
    end
    if (!rsp_valid) begin
      chk("rsp_wait_bound", 0, 1);
      req_valid = 0;
      return;
    end
    if (t.zlat) chk("latency", cyc, 3);
    for (int k = 0; k <= t.rw; k++) begin
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_id", rsp_id, t.id);
      chk("rsp_sum", rsp_sum, t.sum);
      chk("rsp_carry", rsp_carry, t.carry);
      chk("rsp_err", rsp_err, t.err);
      if (k < t.rw) begin @(posedge clk); #1; end
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    req_valid = 0;
    chk("rsp_done", rsp_valid, 0);
    chk("busy_after", busy, 0);
  endtask

  vec_t vecs[12];

  initial begin
    int cyc;
    //             valid    a        b     id s  c  e  aw bw sw cw rw nv zl
    vecs[0]  = mk(4'b0001, 4'b0001, 4'b0001, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    vecs[1]  = mk(4'b1111, 4'b0010, 4'b0000, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    vecs[2]  = mk(4'b1111, 4'b0100, 4'b0100, 2, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1);
    vecs[3]  = mk(4'b1111, 4'b0000, 4'b1000, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    vecs[4]  = mk(4'b1111, 4'b1111, 4'b0000, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    vecs[5]  = mk(4'b0100, 4'b0100, 4'b0000, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    vecs[6]  = mk(4'b0101, 4'b0001, 4'b0001, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    vecs[7]  = mk(4'b0101, 4'b0100, 4'b0100, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    // skewed engine: B 4 cycles after A, carry before sum, slow consumer
    vecs[8]  = mk(4'b0010, 4'b0010, 4'b0000, 1, 1, 0, 0, 0, 4, 1, 0, 3, 0, 0);
    // sum handshake on the watchdog's final cycle wins
    vecs[9]  = mk(4'b1000, 4'b1000, 4'b0000, 3, 1, 0, 0, 0, 0, 6, 0, 0, 0, 0);
    // one cycle later is a timeout
    vecs[10] = mk(4'b0001, 4'b0001, 4'b0000, 0, 0, 0, 1, 0, 0, 7, 0, 0, 0, 0);
    // sum never returns; carry would have been 1 but is forced to 0
    vecs[11] = mk(4'b0010, 4'b0010, 4'b0010, 1, 0, 0, 1, 0, 0, 0, 0, 2, 1, 0);

    aw = 0; bw = 0; sw = 0; cw = 0; never_sum = 0;
    reset = 1; req_valid = 4'b1111; req_a = 4'b1111; req_b = 4'b1111; rsp_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("reset_req_ready", req_ready, 0);
    chk("reset_outs", {ha_a_tvalid, ha_b_tvalid, ha_a_tdata, ha_b_tdata, ha_sum_tready,
                       ha_carry_tready, rsp_valid, rsp_sum, rsp_carry, rsp_err, rsp_id, busy}, 0);
    req_valid = 0; req_a = 0; req_b = 0;
    @(negedge clk); reset = 0;

    for (int i = 0; i < 12; i++) txn(vecs[i]);

    // reset while collecting: transaction dropped, next grant from index 0 up
    sw = 20; cw = 20; never_sum = 0;
    @(negedge clk);
    req_valid = 4'b0100; req_a = 4'b0100; req_b = 4'b0100;
    cyc = 0;
    while (!ha_sum_tready && cyc < 20) begin @(negedge clk); cyc++; end
    chk("reached_collect", ha_sum_tready, 1);
    reset = 1; #1;
    chk("rst_mid_async", {req_ready, ha_a_tvalid, ha_b_tvalid, ha_sum_tready,
                          ha_carry_tready, rsp_valid, rsp_err, busy}, 0);
    @(posedge clk); #1;
    chk("rst_mid_edge", {req_ready, ha_a_tvalid, ha_b_tvalid, ha_sum_tready,
                         ha_carry_tready, rsp_valid, rsp_sum, rsp_carry, rsp_id, busy}, 0);
    @(negedge clk);
    req_valid = 0; reset = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("no_rsp_after_rst", {rsp_valid, busy}, 0);
    end
    txn(mk(4'b1010, 4'b0010, 4'b0000, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
